// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared RISC-V definitions used by the EX/MEM pipeline stage: opcodes, the
// default-width EX/MEM payload record and the link-instruction decode.
package risc_v_pkg;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    localparam int unsigned PAYLOAD_REG_WIDTH  = 32;
    localparam int unsigned PAYLOAD_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [PAYLOAD_REG_WIDTH-1:0]  alu_out;
        logic [PAYLOAD_REG_WIDTH-1:0]  dataB;
        logic [6:0]                    inst_opcode;
        logic [PAYLOAD_ADDR_WIDTH-1:0] rs1;
        logic [PAYLOAD_ADDR_WIDTH-1:0] rs2;
        logic [PAYLOAD_ADDR_WIDTH-1:0] rd;
        logic                          reg_write_en;
        logic                          mem_write_en;
        logic                          wb_sel;
    } ex_mem_payload_t;

    function automatic logic is_link(input logic [6:0] opcode);
        return (opcode == JAL) || (opcode == JALR);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM stage bundle: EX-side payload and handshake, MEM-side registered
// payload and handshake, flush and the back-pressure counter.
interface ex_mem_pipe_reg_if #(
    parameter int REG_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int PC_WIDTH        = 32,
    parameter int STALL_CNT_WIDTH = 16
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [REG_WIDTH-1:0]       alu_out;
    logic [REG_WIDTH-1:0]       dataB;
    logic [PC_WIDTH-1:0]        pc_next;
    logic [6:0]                 inst_opcode;
    logic [REG_ADDR_WIDTH-1:0]  rs1;
    logic [REG_ADDR_WIDTH-1:0]  rs2;
    logic [REG_ADDR_WIDTH-1:0]  rd;
    logic                       reg_write_en;
    logic                       mem_write_en;
    logic                       wb_sel;
    logic                       out_valid;
    logic                       out_ready;
    logic [REG_WIDTH-1:0]       EX_MEM_alu_out;
    logic [REG_WIDTH-1:0]       EX_MEM_dataB;
    logic [6:0]                 EX_MEM_inst_opcode;
    logic [REG_ADDR_WIDTH-1:0]  EX_MEM_rs1;
    logic [REG_ADDR_WIDTH-1:0]  EX_MEM_rs2;
    logic [REG_ADDR_WIDTH-1:0]  EX_MEM_rd;
    logic                       EX_MEM_reg_write_en;
    logic                       EX_MEM_mem_write_en;
    logic                       EX_MEM_wb_sel;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;

    // The pipeline stage itself.
    modport master (
        input  flush, in_valid, alu_out, dataB, pc_next, inst_opcode,
               rs1, rs2, rd, reg_write_en, mem_write_en, wb_sel, out_ready,
        output in_ready, out_valid, EX_MEM_alu_out, EX_MEM_dataB,
               EX_MEM_inst_opcode, EX_MEM_rs1, EX_MEM_rs2, EX_MEM_rd,
               EX_MEM_reg_write_en, EX_MEM_mem_write_en, EX_MEM_wb_sel,
               stall_cnt
    );

    // The surrounding EX and MEM logic.
    modport slave (
        output flush, in_valid, alu_out, dataB, pc_next, inst_opcode,
               rs1, rs2, rd, reg_write_en, mem_write_en, wb_sel, out_ready,
        input  in_ready, out_valid, EX_MEM_alu_out, EX_MEM_dataB,
               EX_MEM_inst_opcode, EX_MEM_rs1, EX_MEM_rs2, EX_MEM_rd,
               EX_MEM_reg_write_en, EX_MEM_mem_write_en, EX_MEM_wb_sel,
               stall_cnt
    );

endinterface

// File: rtl/ex_mem_pipe_reg_skid_buf.sv
// Generic single-entry skid buffer; clear discards the entry, load fills it,
// pop empties it. Used by the EX/MEM stage when EX_MEM_SKID_EN is defined.
module pipe_skid_buf
    import risc_v_pkg::*;
#(
    parameter type T = ex_mem_payload_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic load,
    input  logic pop,
    input  T     data_in,
    output logic valid,
    output T     data_out
);

    logic valid_q;
    T     data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_in;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline stage with valid/ready handshake, flush, bubble insertion,
// JAL/JALR link select and a saturating back-pressure counter.
// Optional skid entry enabled by defining EX_MEM_SKID_EN.
module ex_mem_pipe_reg
    import risc_v_pkg::*;
#(
    parameter int REG_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int PC_WIDTH        = 32,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    ex_mem_pipe_reg_if.master bus
);

    typedef struct packed {
        logic [REG_WIDTH-1:0]      alu_out;
        logic [REG_WIDTH-1:0]      dataB;
        logic [6:0]                inst_opcode;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write_en;
        logic                      mem_write_en;
        logic                      wb_sel;
    } payload_t;

    payload_t                   cap;
    payload_t                   main_q;
    payload_t                   main_src;
    logic                       out_valid_q;
    logic                       main_free;
    logic                       accept;
    logic                       rel;
    logic                       load_main;
    logic                       in_ready;
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    // JAL/JALR write the return address (PC+4) instead of the ALU result.
    always_comb begin
        cap              = '0;
        cap.alu_out      = is_link(bus.inst_opcode) ? REG_WIDTH'(bus.pc_next)
                                                    : bus.alu_out;
        cap.dataB        = bus.dataB;
        cap.inst_opcode  = bus.inst_opcode;
        cap.rs1          = bus.rs1;
        cap.rs2          = bus.rs2;
        cap.rd           = bus.rd;
        cap.reg_write_en = bus.reg_write_en;
        cap.mem_write_en = bus.mem_write_en;
        cap.wb_sel       = bus.wb_sel;
    end

    assign rel       = out_valid_q & bus.out_ready;
    assign main_free = ~out_valid_q | bus.out_ready;
    assign accept    = bus.in_valid & in_ready;

`ifdef EX_MEM_SKID_EN
    logic     skid_valid;
    logic     skid_load;
    logic     skid_pop;
    payload_t skid_data;

    // in_ready depends only on the registered skid state (plus flush), so
    // out_ready no longer reaches in_ready combinationally.
    assign in_ready  = ~bus.flush & ~skid_valid;
    assign skid_load = accept & ~main_free;
    assign skid_pop  = rel & skid_valid;
    assign load_main = ~bus.flush & (skid_pop | (accept & main_free));
    assign main_src  = skid_valid ? skid_data : cap;

    pipe_skid_buf #(
        .T(payload_t)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (bus.flush),
        .load     (skid_load),
        .pop      (skid_pop),
        .data_in  (cap),
        .valid    (skid_valid),
        .data_out (skid_data)
    );
`else
    assign in_ready  = ~bus.flush & main_free;
    assign load_main = accept;
    assign main_src  = cap;
`endif

    // Write enables are cleared on every emptying event so MEM/WB can use
    // them without gating by out_valid; the rest of the payload holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            main_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q         <= 1'b0;
            main_q.reg_write_en <= 1'b0;
            main_q.mem_write_en <= 1'b0;
        end else if (load_main) begin
            out_valid_q <= 1'b1;
            main_q      <= main_src;
        end else if (rel) begin
            out_valid_q         <= 1'b0;
            main_q.reg_write_en <= 1'b0;
            main_q.mem_write_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.in_ready            = in_ready;
    assign bus.out_valid           = out_valid_q;
    assign bus.EX_MEM_alu_out      = main_q.alu_out;
    assign bus.EX_MEM_dataB        = main_q.dataB;
    assign bus.EX_MEM_inst_opcode  = main_q.inst_opcode;
    assign bus.EX_MEM_rs1          = main_q.rs1;
    assign bus.EX_MEM_rs2          = main_q.rs2;
    assign bus.EX_MEM_rd           = main_q.rd;
    assign bus.EX_MEM_reg_write_en = main_q.reg_write_en;
    assign bus.EX_MEM_mem_write_en = main_q.mem_write_en;
    assign bus.EX_MEM_wb_sel       = main_q.wb_sel;
    assign bus.stall_cnt           = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: queue-based reference model compared
// every cycle, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_ex_mem_pipe_reg;

    localparam int RW = 32;
    localparam int AW = 5;
    localparam int PW = 32;
    localparam int SW = 16;
    localparam int unsigned STALL_MAX = 65535;
`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_pipe_reg_if #(
        .REG_WIDTH(RW), .REG_ADDR_WIDTH(AW), .PC_WIDTH(PW), .STALL_CNT_WIDTH(SW)
    ) bus ();

    ex_mem_pipe_reg #(
        .REG_WIDTH(RW), .REG_ADDR_WIDTH(AW), .PC_WIDTH(PW), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] db;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rwe;
        logic        mwe;
        logic        wb;
    } ent_t;

    // Model: the stage is a FIFO of in-flight instructions of depth CAP;
    // the MEM side shows its head, or the last head with write enables cleared.
    ent_t        q[$];
    ent_t        shown = '0;
    int unsigned m_stall = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic model_ready();
        if (bus.flush) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || bus.out_ready;
    endfunction

    function automatic ent_t make_entry();
        ent_t e;
        e.alu = (bus.inst_opcode == 7'h6F || bus.inst_opcode == 7'h67) ? bus.pc_next : bus.alu_out;
        e.db  = bus.dataB;
        e.op  = bus.inst_opcode;
        e.rs1 = bus.rs1;
        e.rs2 = bus.rs2;
        e.rd  = bus.rd;
        e.rwe = bus.reg_write_en;
        e.mwe = bus.mem_write_en;
        e.wb  = bus.wb_sel;
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            shown = '0;
            m_stall = 0;
        end else begin
            logic rel, acc;
            rel = (q.size() != 0) && bus.out_ready;
            acc = bus.in_valid && model_ready();
            if (q.size() != 0 && !bus.out_ready && m_stall != STALL_MAX) m_stall++;
            if (rel) void'(q.pop_front());
            if (bus.flush) q.delete();
            else if (acc) q.push_back(make_entry());
            if (q.size() != 0) begin
                shown = q[0];
            end else begin
                shown.rwe = 1'b0;
                shown.mwe = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
            chk("alu_out", 64'(bus.EX_MEM_alu_out), 64'(shown.alu));
            chk("dataB", 64'(bus.EX_MEM_dataB), 64'(shown.db));
            chk("opcode", 64'(bus.EX_MEM_inst_opcode), 64'(shown.op));
            chk("rs1", 64'(bus.EX_MEM_rs1), 64'(shown.rs1));
            chk("rs2", 64'(bus.EX_MEM_rs2), 64'(shown.rs2));
            chk("rd", 64'(bus.EX_MEM_rd), 64'(shown.rd));
            chk("reg_we", 64'(bus.EX_MEM_reg_write_en), 64'(shown.rwe));
            chk("mem_we", 64'(bus.EX_MEM_mem_write_en), 64'(shown.mwe));
            chk("wb_sel", 64'(bus.EX_MEM_wb_sel), 64'(shown.wb));
            chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
        end
    end

    // One clock; an instruction the stage accepted is withdrawn from EX.
    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = bus.in_valid & bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) bus.in_valid = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] db,
                         input logic [31:0] pc, input logic [4:0] rd,
                         input logic rwe, input logic mwe, input logic wb);
        bus.inst_opcode  = op;
        bus.alu_out      = alu;
        bus.dataB        = db;
        bus.pc_next      = pc;
        bus.rs1          = rd + 5'd1;
        bus.rs2          = rd + 5'd2;
        bus.rd           = rd;
        bus.reg_write_en = rwe;
        bus.mem_write_en = mwe;
        bus.wb_sel       = wb;
        bus.in_valid     = 1'b1;
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.alu_out = '0; bus.dataB = '0; bus.pc_next = '0; bus.inst_opcode = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
        bus.reg_write_en = 1'b0; bus.mem_write_en = 1'b0; bus.wb_sel = 1'b0;
        tick(); tick();
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst alu_out", 64'(bus.EX_MEM_alu_out), 64'd0);
        reset_n = 1'b1;
        tick();

        // ADD, single cycle through, then a bubble
        bus.out_ready = 1'b1;
        drive(7'h33, 32'h0000_0010, 32'h55, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("add in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("add out_valid", 64'(bus.out_valid), 64'd1);
        chk("add alu_out", 64'(bus.EX_MEM_alu_out), 64'h10);
        chk("add rd", 64'(bus.EX_MEM_rd), 64'd5);
        tick();
        chk("bubble out_valid", 64'(bus.out_valid), 64'd0);
        chk("bubble reg_we", 64'(bus.EX_MEM_reg_write_en), 64'd0);
        chk("bubble mem_we", 64'(bus.EX_MEM_mem_write_en), 64'd0);

        // JAL then JALR back to back
        drive(7'h6F, 32'hDEAD_BEEF, 32'h0, 32'h0000_1004, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("jal link", 64'(bus.EX_MEM_alu_out), 64'h1004);
        drive(7'h67, 32'hDEAD_BEEF, 32'h0, 32'h0000_2008, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("jalr link", 64'(bus.EX_MEM_alu_out), 64'h2008);
        chk("jalr out_valid", 64'(bus.out_valid), 64'd1);
        tick();

        // Back-pressure for 3 cycles with a second instruction waiting
        bus.out_ready = 1'b0;
        drive(7'h23, 32'h0000_0100, 32'h0000_CAFE, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(7'h33, 32'h0000_0200, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
        chk("stall in_ready0", 64'(bus.in_ready), 64'(CAP == 2));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall in_ready", 64'(bus.in_ready), 64'd0);
        end
        chk("stall cnt3", 64'(bus.stall_cnt), 64'd3);
        chk("stall alu_out", 64'(bus.EX_MEM_alu_out), 64'h100);
        chk("stall dataB", 64'(bus.EX_MEM_dataB), 64'hCAFE);
        bus.out_ready = 1'b1;
        tick();
        chk("order alu_out", 64'(bus.EX_MEM_alu_out), 64'h200);
        chk("order rd", 64'(bus.EX_MEM_rd), 64'd7);
        tick();
        chk("drain out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain stall_cnt", 64'(bus.stall_cnt), 64'd3);

        // Flush with a full stage and a valid input
        bus.out_ready = 1'b0;
        drive(7'h23, 32'h0000_0300, 32'h1, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        drive(7'h33, 32'h0000_0400, 32'h2, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        chk("flush in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush reg_we", 64'(bus.EX_MEM_reg_write_en), 64'd0);
        chk("flush mem_we", 64'(bus.EX_MEM_mem_write_en), 64'd0);
        chk("flush alu_out", 64'(bus.EX_MEM_alu_out), 64'h300);
        chk("flush stall_cnt", 64'(bus.stall_cnt), 64'd4);

        // Flush in the same cycle as a release
        bus.out_ready = 1'b1;
        drive(7'h33, 32'h0000_0500, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush+rel out_valid", 64'(bus.out_valid), 64'd0);

        // Long stall saturates the counter
        bus.out_ready = 1'b0;
        drive(7'h33, 32'h0000_0600, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(7'h33, 32'h0000_0700, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) tick();
        chk("sat stall_cnt", 64'(bus.stall_cnt), 64'hFFFF);
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("sat hold", 64'(bus.stall_cnt), 64'hFFFF);

        // Asynchronous reset between edges while stalled
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("arst alu_out", 64'(bus.EX_MEM_alu_out), 64'd0);
        chk("arst rd", 64'(bus.EX_MEM_rd), 64'd0);
        chk("arst reg_we", 64'(bus.EX_MEM_reg_write_en), 64'd0);
        chk("arst mem_we", 64'(bus.EX_MEM_mem_write_en), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("post-rst empty", 64'(bus.out_valid), 64'd0);
        tick();
        chk("post-rst empty2", 64'(bus.out_valid), 64'd0);
        drive(7'h33, 32'h0000_0800, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post-rst alu_out", 64'(bus.EX_MEM_alu_out), 64'h800);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline stage for the RISC-V 5-stage core. It replaces the free-running stage register with a valid/ready handshake, synchronous flush and bubble insertion, so EX can be stalled by MEM back-pressure, for example a multi-cycle data memory. It also selects the link address for JAL/JALR and keeps a saturating back-pressure counter for performance analysis. It sits between the ALU/forwarding logic in EX and the data-memory/WB logic in MEM.

## Interface
Parameters:
- REG_WIDTH, default 32: datapath width.
- REG_ADDR_WIDTH, default 5: register index width.
- PC_WIDTH, default 32: PC width. Legal range is PC_WIDTH ≤ REG_WIDTH.
- STALL_CNT_WIDTH, default 16: width of the back-pressure counter.

Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- flush, in, 1: synchronous kill of the stage contents.
- in_valid, in, 1: EX presents a valid instruction.
- in_ready, out, 1: stage can accept.
- alu_out, in, REG_WIDTH: ALU result.
- dataB, in, REG_WIDTH: store data.
- pc_next, in, PC_WIDTH: PC+4 of the EX instruction.
- inst_opcode, in, 7: opcode.
- rs1, in, REG_ADDR_WIDTH: source register 1.
- rs2, in, REG_ADDR_WIDTH: source register 2.
- rd, in, REG_ADDR_WIDTH: destination register.
- reg_write_en, in, 1: register write enable.
- mem_write_en, in, 1: memory write enable.
- wb_sel, in, 1: writeback select.
- out_valid, out, 1: the MEM-side payload is valid.
- out_ready, in, 1: MEM consumes the payload.
- EX_MEM_alu_out, EX_MEM_dataB, EX_MEM_inst_opcode, EX_MEM_rs1, EX_MEM_rs2, EX_MEM_rd, EX_MEM_reg_write_en, EX_MEM_mem_write_en, EX_MEM_wb_sel, out, widths as the matching inputs: registered payload.
- stall_cnt, out, STALL_CNT_WIDTH: count of back-pressured cycles.

## Operation
- Definitions:
  - accept = in_valid & in_ready.
  - release = out_valid & out_ready.
- Link select on capture:
  - If inst_opcode is JAL or JALR, EX_MEM_alu_out is pc_next zero-extended to REG_WIDTH.
  - Otherwise EX_MEM_alu_out is alu_out.
- Main register update priority, highest first:
  1. flush: out_valid←0, EX_MEM_reg_write_en←0, EX_MEM_mem_write_en←0. The skid entry, if present, is discarded.
  2. accept: capture the full payload and set out_valid←1. This applies when the main register is empty or being released; otherwise the capture goes to the skid entry.
  3. release without accept: out_valid←0 and both write enables←0, which inserts a bubble. The other payload fields hold their values.
  4. Otherwise: hold.
- While flush=1, in_ready=0, so an instruction presented in the flush cycle is dropped. EX upstream must also be flushed.
- While out_valid=0, both EX_MEM write enables are guaranteed 0. MEM/WB may therefore use them ungated.
- stall_cnt:
  - Increments each cycle with out_valid & ~out_ready.
  - Saturates at all-ones.
  - Is not cleared by flush; only reset clears it.
- Reset (asynchronous, including mid-transfer): every output register is 0, i.e. out_valid=0, all EX_MEM_* fields 0, stall_cnt=0, skid empty.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready without skid: in_ready = ~flush & (~out_valid | out_ready). This is a combinational path from out_ready.
- Payload stability: must not change while out_valid=1 and out_ready=0.
- Flush asserted in the same cycle as release: the release completes, and the stage is empty the next cycle.
- out_valid and stall_cnt come directly from flops.

## Configuration
- Macro: EX_MEM_SKID_EN.
- Defined:
  - Adds one skid entry.
  - in_ready = ~flush & ~skid_valid, which is registered apart from flush. This breaks the out_ready→in_ready path.
  - An accept while the main register is full and not released loads the skid entry.
  - On release, the skid entry moves to the main register, with out_valid staying 1.
  - Capacity is 2 instructions.
- Undefined:
  - No skid storage; capacity is 1.
  - The combinational in_ready above applies.

## Structure
- Package risc_v_pkg (shared) holds:
  - The opcode constants JAL = 7'b1101111 and JALR = 7'b1100111.
  - The ex_mem_payload_t packed struct, covering alu/link, dataB, opcode, rs1, rs2, rd and the three control bits.
- Sub-module pipe_skid_buf:
  - A generic single-entry skid holding ex_mem_payload_t.
  - Instantiated only under EX_MEM_SKID_EN.
  - The link mux and stall counter stay in the top.

## Test plan
- Reset, then ADD with alu_out=0x0000_0010, rd=5, out_ready=1 → next cycle out_valid=1, EX_MEM_alu_out=0x10, EX_MEM_rd=5; following idle cycle: out_valid=0 and both write enables 0.
- JAL with pc_next=0x0000_1004, alu_out=0xDEAD_BEEF → EX_MEM_alu_out=0x0000_1004. Repeat with JALR.
- Hold out_ready=0 for 3 cycles with a valid entry → payload stable, stall_cnt=3. Without skid: in_ready=0 throughout. With skid: exactly one more accept, then in_ready=0; release ordering preserved.
- flush with in_valid=1 and out_valid=1 → next cycle out_valid=0, EX_MEM_reg_write_en=0, EX_MEM_mem_write_en=0; the input is not captured.
- Force stall_cnt to 0xFFFF via a long stall (STALL_CNT_WIDTH=16) → stays at 0xFFFF.
- Assert reset_n=0 mid-stall, asynchronously between edges → all outputs 0 immediately; skid empty after release of reset.
